seq_detector_param: RTL and testbench

Runtime-programmable serial sequence detector, successor to the fixed single-pattern FSM detector. A pattern of 1..MAX_LEN bits and a matching mode are loaded at run time. The block watches a qualified 1-bit serial input and pulses `out` for each occurrence of the pattern, in either overlapping or non-overlapping mode. It sits on a serial bitstream behind a framing or control block.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_detector_param_if.sv | 33 +++
 rtl/seq_det_hist.sv | 52 +++++
 rtl/seq_detector_param.sv | 95 +++++++++
 tb/tb_seq_detector_param.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// Holds the FSM state encoding, a clog2 helper and the default pattern width.
package seq_det_pkg;

   localparam int MAX_LEN_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } st_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial bit stream, run-time configuration and match outputs
// of the programmable sequence detector.
interface seq_detector_param_if
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int LEN_W   = clog2(MAX_LEN + 1),
   parameter int CNT_W   = 16
);

   logic               in_valid;
   logic               in;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               out;
   logic               armed;
   logic [CNT_W-1:0]   match_cnt;

   modport master (
      output in_valid, in, cfg_load,
      output cfg_pattern, cfg_len, cfg_overlap,
      input  out, armed, match_cnt
   );

   modport slave (
      input  in_valid, in, cfg_load,
      input  cfg_pattern, cfg_len, cfg_overlap,
      output out, armed, match_cnt
   );

endinterface

// File: rtl/seq_det_hist.sv
// History shift register, saturating fill count and length-masked
// compare; hit reflects the history as it will be after this shift.
module seq_det_hist
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int LEN_W   = clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift,
   input  logic               din,
   input  logic [MAX_LEN-1:0] pat,
   input  logic [LEN_W-1:0]   len,
   output logic               hit,
   output logic               full
);

   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] hist_nx;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   fill;
   logic [LEN_W-1:0]   fill_nx;

   always_comb begin
      hist_nx = {hist[MAX_LEN-2:0], din};
      fill_nx = fill;
      if (fill != LEN_W'(MAX_LEN))
         fill_nx = fill + LEN_W'(1);
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (i < int'(len));
      full = (fill_nx >= len);
      hit  = shift && full &&
             (((hist_nx ^ pat) & mask) == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= hist_nx;
         fill <= fill_nx;
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector (overlap / non-overlap).
// Define SEQDET_MATCH_COUNT_EN to build the saturating match counter.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_detector_param_if.slave  bus
);

   localparam int LEN_W = clog2(MAX_LEN + 1);

   st_t                state;
   logic [MAX_LEN-1:0] pat;
   logic [LEN_W-1:0]   len;
   logic [LEN_W-1:0]   len_c;
   logic               ovl;
   logic               out_q;
   logic               shift;
   logic               clr;
   logic               hit;
   logic               full;

   assign len_c = (bus.cfg_len > LEN_W'(MAX_LEN)) ?
                  LEN_W'(MAX_LEN) : bus.cfg_len;

   // A load wins over a bit arriving in the same cycle.
   assign shift = bus.in_valid && (state != IDLE) && !bus.cfg_load;
   assign clr   = bus.cfg_load || (hit && !ovl);

   seq_det_hist #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_hist (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .shift (shift),
      .din   (bus.in),
      .pat   (pat),
      .len   (len),
      .hit   (hit),
      .full  (full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         pat   <= '0;
         len   <= '0;
         ovl   <= 1'b0;
         out_q <= 1'b0;
      end else if (bus.cfg_load) begin
         pat   <= bus.cfg_pattern;
         len   <= len_c;
         ovl   <= bus.cfg_overlap;
         out_q <= 1'b0;
         state <= (len_c == '0) ? IDLE : FILL;
      end else begin
         out_q <= hit;
         if (shift) begin
            if (hit && !ovl)
               state <= FILL;
            else if (full)
               state <= RUN;
            else
               state <= FILL;
         end
      end
   end

   assign bus.out   = out_q;
   assign bus.armed = (state != IDLE);

`ifdef SEQDET_MATCH_COUNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (bus.cfg_load)
         cnt <= '0;
      else if (hit && !(&cnt))
         cnt <= cnt + CNT_W'(1);
   end

   assign bus.match_cnt = cnt;
`else
   assign bus.match_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Table-driven bench for seq_detector_param with an expectation queue,
// plus hand-written reset and counter-saturation sequences.
module tb_seq_detector_param;
   import seq_det_pkg::*;

   localparam int ML = 8;
   localparam int LW = clog2(ML + 1);
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   seq_detector_param_if #(
      .MAX_LEN (ML),
      .LEN_W   (LW),
      .CNT_W   (CW)
   ) bus ();

   seq_detector_param #(
      .MAX_LEN (ML),
      .CNT_W   (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic          ld;
      logic          v;
      logic          b;
      logic [ML-1:0] p;
      logic [LW-1:0] l;
      logic          o;
      logic          eo;
      logic          ea;
      int            es;
      int            ec;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   idx   = 0;

   task automatic cmp(string nm, int act, int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, req);
      end
   endtask

   function automatic void cfg(int p, int l, int o, int ea,
                               int es, int ec,
                               int v = 0, int b = 0);
      vec_t t;
      t.ld = 1'b1;
      t.v  = (v != 0);
      t.b  = (b != 0);
      t.p  = ML'(p);
      t.l  = LW'(l);
      t.o  = (o != 0);
      t.eo = 1'b0;
      t.ea = (ea != 0);
      t.es = es;
      t.ec = ec;
      tbl.push_back(t);
   endfunction

   function automatic void vb(int v, int b, int eo, int ea,
                              int es, int ec);
      vec_t t;
      t.ld = 1'b0;
      t.v  = (v != 0);
      t.b  = (b != 0);
      t.p  = '0;
      t.l  = '0;
      t.o  = 1'b0;
      t.eo = (eo != 0);
      t.ea = (ea != 0);
      t.es = es;
      t.ec = ec;
      tbl.push_back(t);
   endfunction

   function automatic void bt(int b, int eo, int ea = 1,
                              int es = -1, int ec = -1);
      vb(1, b, eo, ea, es, ec);
   endfunction

   function automatic void gap();
      vb(0, 1, 0, 1, 1, -1);
   endfunction

   task automatic check(vec_t e, int n);
      cmp($sformatf("v%0d out", n), int'(bus.out), int'(e.eo));
      cmp($sformatf("v%0d armed", n), int'(bus.armed), int'(e.ea));
      if (e.es >= 0)
         cmp($sformatf("v%0d state", n), int'(dut.state), e.es);
      if (e.ec >= 0) begin
`ifdef SEQDET_MATCH_COUNT_EN
         cmp($sformatf("v%0d cnt", n), int'(bus.match_cnt), e.ec);
`else
         cmp($sformatf("v%0d cnt", n), int'(bus.match_cnt), 0);
`endif
      end
   endtask

   task automatic apply(vec_t t);
      vec_t e;
      @(negedge clk);
      bus.cfg_load    = t.ld;
      bus.cfg_pattern = t.p;
      bus.cfg_len     = t.l;
      bus.cfg_overlap = t.o;
      bus.in_valid    = t.v;
      bus.in          = t.b;
      exp_q.push_back(t);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(e, idx);
      idx++;
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) apply(tbl[i]);
      tbl.delete();
   endtask

   initial begin
      bus.cfg_load    = 1'b0;
      bus.cfg_pattern = '0;
      bus.cfg_len     = '0;
      bus.cfg_overlap = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in          = 1'b0;

      #1;
      cmp("rst out", int'(bus.out), 0);
      cmp("rst armed", int'(bus.armed), 0);
      cmp("rst state", int'(dut.state), 0);
      cmp("rst cnt", int'(bus.match_cnt), 0);

      // a load while reset is held must not arm the block
      @(negedge clk);
      bus.cfg_load    = 1'b1;
      bus.cfg_pattern = ML'(8'h0D);
      bus.cfg_len     = LW'(4);
      bus.cfg_overlap = 1'b1;
      #3;
      bus.cfg_load = 1'b0;
      cmp("rst hold armed", int'(bus.armed), 0);
      #2;
      rst = 1'b1;

      // no configuration: bits ignored
      bt(1, 0, 0, 0); bt(1, 0, 0, 0); bt(0, 0, 0, 0); bt(1, 0, 0, 0);

      // 1101 overlapping
      cfg(8'h0D, 4, 1, 1, 1, 0);
      bt(0, 0); bt(1, 0); bt(1, 0); bt(0, 0, 1, 2);
      bt(1, 1, 1, 2, 1); bt(1, 0); bt(0, 0);
      bt(1, 1, 1, 2, 2); bt(0, 0, 1, -1, 2);

      // 1101 non-overlapping
      cfg(8'h0D, 4, 0, 1, 1, 0);
      bt(0, 0); bt(1, 0); bt(1, 0); bt(0, 0, 1, 2);
      bt(1, 1, 1, 1, 1); bt(1, 0); bt(0, 0);
      bt(1, 0, 1, 1); bt(0, 0, 1, 2, 1);

      // in_valid gaps; pattern bits above len are don't-care
      cfg(8'hFD, 4, 1, 1, 1, 0);
      bt(1, 0); bt(1, 0); bt(0, 0);
      gap(); gap(); gap();
      bt(1, 1, 1, 2, 1);

      // load with a bit in the same cycle: that bit is dropped
      cfg(8'h05, 3, 1, 1, 1, 0, 1, 1);
      bt(0, 0); bt(1, 0, 1, 1); bt(0, 0, 1, 2); bt(1, 1, 1, 2, 1);

      // zero length disarms
      cfg(8'h05, 0, 1, 0, 0, 0);
      bt(1, 0, 0, 0); bt(0, 0, 0, 0); bt(1, 0, 0, 0);

      // over-long length clamps to MAX_LEN
      cfg(8'hA5, 15, 0, 1, 1, 0);
      bt(1, 0); bt(0, 0); bt(1, 0); bt(0, 0);
      bt(0, 0); bt(1, 0); bt(0, 0, 1, 1);
      bt(1, 1, 1, 1, 1);

      // length 1, both modes
      cfg(8'h01, 1, 0, 1, 1, 0);
      bt(1, 1, 1, 1); bt(0, 0, 1, 2); bt(1, 1); bt(1, 1, 1, 1, 3);
      cfg(8'hFE, 1, 1, 1, 1, 0);
      bt(1, 0, 1, 2); bt(0, 1, 1, 2, 1);

      run_tbl();

      // asynchronous reset right after a match pulse
      cfg(8'h0D, 4, 1, 1, 1, 0);
      bt(1, 0); bt(1, 0); bt(0, 0); bt(1, 1, 1, 2, 1);
      run_tbl();
      bus.in_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      cmp("arst out", int'(bus.out), 0);
      cmp("arst state", int'(dut.state), 0);
      cmp("arst armed", int'(bus.armed), 0);
      cmp("arst cnt", int'(bus.match_cnt), 0);
      @(negedge clk);
      rst = 1'b1;

      // pattern lost after reset
      bt(1, 0, 0, 0); bt(1, 0, 0, 0); bt(0, 0, 0, 0); bt(1, 0, 0, 0);
      run_tbl();

      // counter saturation at len 1
      cfg(8'h01, 1, 1, 1, 1, 0);
      for (int i = 1; i <= (1 << CW) + 1; i++)
         bt(1, 1, 1, 2, (i > (1 << CW) - 1) ? (1 << CW) - 1 : i);
      run_tbl();

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
